swervolf_btn_irq: RTL

//  Debounced push-button/switch input conditioner with edge-detect interrupt logic.

---
 rtl/swervolf_btn_irq_if.sv | 13 +
 rtl/swervolf_btn_irq.sv | 95 +++++++++
 2 files changed

// File: rtl/swervolf_btn_irq_if.sv
// swervolf_btn_irq_if: Wishbone slave port bundle for the button/IRQ peripheral.
interface swervolf_btn_irq_if;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] rdt;
    logic        ack;
    modport master (output adr, dat, sel, we, cyc, stb, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack);
endinterface

// File: rtl/swervolf_btn_irq.sv
// swervolf_btn_irq: debounced button inputs with edge-detect level IRQ on a Wishbone slave.
// Defining SWERVOLF_BTN_EVCNT_EN adds a saturating 16-bit event counter at offset 0x14.
module swervolf_btn_irq #(
    parameter int N_IN            = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_IN-1:0]   i_btn,
    swervolf_btn_irq_if.slave wb,
    output logic [N_IN-1:0]   o_btn_db,
    output logic              o_irq
);
    logic [N_IN-1:0] r_s1, r_s2, r_re, r_fe, r_pend, r_ie;
    logic [N_IN-1:0] w_upd, w_set, w_clr, w_m, w_d;
    logic [31:0]     w_mask, w_rd;
    logic [2:0]      w_idx;
    logic            w_acc, w_wr;
    logic            w_unused;
    assign w_acc    = wb.cyc & wb.stb & ~wb.ack;
    assign w_wr     = w_acc & wb.we;
    assign w_idx    = wb.adr[4:2];
    assign w_mask   = {{8{wb.sel[3]}}, {8{wb.sel[2]}}, {8{wb.sel[1]}}, {8{wb.sel[0]}}};
    assign w_m      = w_mask[N_IN-1:0];
    assign w_d      = wb.dat[N_IN-1:0];
    assign w_clr    = (w_wr && w_idx == 3'd3) ? (w_d & w_m) : '0;
    assign w_set    = w_upd & ((r_s2 & r_re) | (~r_s2 & r_fe));
    assign w_unused = &{1'b0, wb.adr[1:0], wb.dat, w_mask};
    // The counter only runs while the synchronized input disagrees with the accepted level.
    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        assign w_upd[i] = (r_s2[i] != o_btn_db[i]) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
        always_ff @(posedge i_clk) begin
            if (i_rst || r_s2[i] == o_btn_db[i] || w_upd[i])
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end
`ifdef SWERVOLF_BTN_EVCNT_EN
    logic [15:0] r_ev;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ev <= '0;
        else if (w_wr && w_idx == 3'd5 && (wb.sel[0] | wb.sel[1]))
            r_ev <= '0;
        else if (|(w_set & ~r_pend) && r_ev != 16'hffff)
            r_ev <= r_ev + 1'b1;
    end
`endif
    always_comb begin
        w_rd = '0;
        case (w_idx)
            3'd0: w_rd[N_IN-1:0] = o_btn_db;
            3'd1: w_rd[N_IN-1:0] = r_re;
            3'd2: w_rd[N_IN-1:0] = r_fe;
            3'd3: w_rd[N_IN-1:0] = r_pend;
            3'd4: w_rd[N_IN-1:0] = r_ie;
`ifdef SWERVOLF_BTN_EVCNT_EN
            3'd5: w_rd[15:0] = r_ev;
`endif
            default: w_rd = '0;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            o_btn_db <= '0;
            r_re     <= '0;
            r_fe     <= '0;
            r_pend   <= '0;
            r_ie     <= '0;
            o_irq    <= 1'b0;
            wb.ack   <= 1'b0;
            wb.rdt   <= '0;
        end else begin
            r_s1     <= i_btn;
            r_s2     <= r_s1;
            o_btn_db <= o_btn_db ^ w_upd;
            r_pend   <= (r_pend & ~w_clr) | w_set;
            o_irq    <= |(r_pend & r_ie);
            wb.ack   <= w_acc;
            if (w_acc)
                wb.rdt <= w_rd;
            if (w_wr && w_idx == 3'd1)
                r_re <= (r_re & ~w_m) | (w_d & w_m);
            if (w_wr && w_idx == 3'd2)
                r_fe <= (r_fe & ~w_m) | (w_d & w_m);
            if (w_wr && w_idx == 3'd4)
                r_ie <= (r_ie & ~w_m) | (w_d & w_m);
        end
    end
endmodule
